// File: rtl/muldiv_pkg.sv
//------------------------------------------------------------------------------
// muldiv_pkg : shared op codes, FSM state encoding and watchdog default
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam int TIMEOUT_DEFAULT = 40;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_M_START = 3'd1,
    S_M_WAIT  = 3'd2,
    S_D_START = 3'd3,
    S_D_WAIT  = 3'd4,
    S_DONE    = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_watchdog.sv
//------------------------------------------------------------------------------
// muldiv_watchdog : clearable up-counter flagging the cycle it would hit TIMEOUT
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_watchdog #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam int c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_term = c_cnt_w'(TIMEOUT);

  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] w_next;

  assign w_next = r_count + c_cnt_w'(1);

  // Expiry is flagged on the edge whose increment lands on TIMEOUT.
  assign o_expired = i_inc && (w_next == c_term);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
//------------------------------------------------------------------------------
// muldiv_ctrl : sequences MULT/DIV/MTHI/MTLO, owns HI/LO, reports done/flags
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        mult_start,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        mult_end,
  output logic        div_start,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_end,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout
);

  state_e r_state;
  logic   w_wd_clear;
  logic   w_wd_inc;
  logic   w_wd_expired;

  assign w_wd_clear = (r_state == S_M_START) || (r_state == S_D_START);
  assign w_wd_inc   = (r_state == S_M_WAIT)  || (r_state == S_D_WAIT);

  muldiv_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_wd_clear),
    .i_inc     (w_wd_inc),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      HI         <= '0;
      LO         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      timeout    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            case (op)
              OP_MULT: begin
                op_a       <= A;
                op_b       <= B;
                mult_start <= 1'b1;
                busy       <= 1'b1;
                r_state    <= S_M_START;
              end
              OP_DIV: begin
                if (B == 32'd0) begin
                  done     <= 1'b1;
                  div_zero <= 1'b1;
                  r_state  <= S_DONE;
                end else begin
                  op_a      <= A;
                  op_b      <= B;
                  div_start <= 1'b1;
                  busy      <= 1'b1;
                  r_state   <= S_D_START;
                end
              end
              OP_MTHI: HI <= A;
              default: LO <= A;
            endcase
          end
        end
        // End flags are not looked at here: the unit clears any stale level
        // on the edge that samples the start pulse.
        S_M_START: r_state <= S_M_WAIT;
        S_D_START: r_state <= S_D_WAIT;
        S_M_WAIT: begin
          if (mult_end) begin
            HI      <= mult_hi;
            LO      <= mult_lo;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else if (w_wd_expired) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_D_WAIT: begin
          if (div_end) begin
            HI      <= div_hi;
            LO      <= div_lo;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else if (w_wd_expired) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
//------------------------------------------------------------------------------
// tb_muldiv_ctrl : behavioural multiplier/divider units plus HI/LO model
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_ctrl;

  localparam int TO = 40;
  localparam logic [1:0] K_MULT = 2'b00;
  localparam logic [1:0] K_DIV  = 2'b01;
  localparam logic [1:0] K_MTHI = 2'b10;
  localparam logic [1:0] K_MTLO = 2'b11;

  logic        clock, reset, op_valid;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        mult_start, mult_end, div_start, div_end;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic [31:0] op_a, op_b, HI, LO;
  logic        busy, done, div_zero, timeout;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_hi   = '0;
  logic [31:0] exp_lo   = '0;
  int          d_lat    = 10;
  bit          d_never  = 1'b0;

  muldiv_ctrl #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op(op), .A(A), .B(B),
    .mult_start(mult_start), .mult_hi(mult_hi), .mult_lo(mult_lo), .mult_end(mult_end),
    .div_start(div_start), .div_hi(div_hi), .div_lo(div_lo), .div_end(div_end),
    .op_a(op_a), .op_b(op_b), .HI(HI), .LO(LO),
    .busy(busy), .done(done), .div_zero(div_zero), .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  function automatic logic [31:0] quo(input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 32'(sa / sb);
  endfunction

  function automatic logic [31:0] rem(input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 32'(sa % sb);
  endfunction

  // 32-iteration multiplier: end level cleared when start is sampled
  logic [63:0] m_res;
  int          m_cnt;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mult_end <= 1'b0; m_cnt <= 0; m_res <= '0; mult_hi <= '0; mult_lo <= '0;
    end else if (mult_start) begin
      mult_end <= 1'b0; m_cnt <= 32; m_res <= mul64(op_a, op_b);
      mult_hi <= 32'hDEAD_BEEF; mult_lo <= 32'hDEAD_BEEF;
    end else if (m_cnt == 1) begin
      mult_end <= 1'b1; mult_hi <= m_res[63:32]; mult_lo <= m_res[31:0]; m_cnt <= 0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end
  end

  // Divider stub with programmable latency, or no end at all
  logic [31:0] d_q, d_r;
  int          d_cnt;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_end <= 1'b0; d_cnt <= 0; d_q <= '0; d_r <= '0; div_hi <= '0; div_lo <= '0;
    end else if (div_start) begin
      div_end <= 1'b0; d_cnt <= d_never ? 0 : d_lat;
      d_q <= quo(op_a, op_b); d_r <= rem(op_a, op_b);
      div_hi <= 32'hBAAD_F00D; div_lo <= 32'hBAAD_F00D;
    end else if (d_cnt == 1) begin
      div_end <= 1'b1; div_hi <= d_r; div_lo <= d_q; d_cnt <= 0;
    end else if (d_cnt > 1) begin
      d_cnt <= d_cnt - 1;
    end
  end

  // Issues one request and observes it; cycle k is the k-th cycle after acceptance
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int limit, input bit poke,
                        output int lat, output int n_ms, output int n_ds, output int n_done,
                        output int n_busy, output int n_dz, output int n_to,
                        output logic [31:0] hi0, output logic [31:0] lo0);
    lat = -1; n_ms = 0; n_ds = 0; n_done = 0; n_busy = 0; n_dz = 0; n_to = 0;
    hi0 = '0; lo0 = '0;
    @(negedge clock);
    op_valid = 1'b1; op = o; A = a; B = b;
    @(posedge clock);
    for (int k = 0; k < limit; k++) begin
      @(negedge clock);
      if (k == 0) begin op_valid = 1'b0; hi0 = HI; lo0 = LO; end
      if (poke && k == 5) begin op_valid = 1'b1; op = K_MULT; A = $urandom; B = $urandom; end
      if (poke && k == 7) op_valid = 1'b0;
      if (mult_start) n_ms++;
      if (div_start)  n_ds++;
      if (busy)       n_busy++;
      if (div_zero)   n_dz++;
      if (timeout)    n_to++;
      if (done) begin n_done++; if (lat < 0) lat = k; end
      if (lat >= 0 && k >= lat + 3) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; op_valid = 1'b0; op = '0; A = '0; B = '0;
    @(negedge clock);
    checks++;
    if ({HI, LO, op_a, op_b} !== 128'd0) begin
      failures++; $display("FAIL reset_regs got=%h/%h/%h/%h exp=0", HI, LO, op_a, op_b);
    end
    checks++;
    if ({busy, done, div_zero, timeout, mult_start, div_start} !== 6'd0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000", {busy, done, div_zero, timeout, mult_start, div_start});
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, HI, LO} !== 66'd0) begin
      failures++; $display("FAIL reset_release got busy=%b done=%b HI=%h LO=%h exp=0", busy, done, HI, LO);
    end
  endtask

  task automatic test_mult_basic();
    int lat, ms, ds, nd, nb, dz, to;
    logic [31:0] h0, l0;
    run_op(K_MULT, 32'd7, 32'hFFFF_FFFD, 60, 1'b0, lat, ms, ds, nd, nb, dz, to, h0, l0);
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFEB;
    checks++; if (lat !== 34) begin failures++; $display("FAIL mult_lat got=%0d exp=34", lat); end
    checks++; if (ms !== 1) begin failures++; $display("FAIL mult_start_width got=%0d exp=1", ms); end
    checks++; if (ds !== 0) begin failures++; $display("FAIL mult_no_div_start got=%0d exp=0", ds); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL mult_done_count got=%0d exp=1", nd); end
    checks++; if (nb !== 34) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=34", nb); end
    checks++; if (dz + to !== 0) begin failures++; $display("FAIL mult_flags got=%0d exp=0", dz + to); end
    checks++;
    if (HI !== exp_hi || LO !== exp_lo) begin
      failures++; $display("FAIL mult_result got=%h_%h exp=%h_%h", HI, LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_div_basic();
    int lat, ms, ds, nd, nb, dz, to;
    logic [31:0] h0, l0;
    d_lat = 10; d_never = 1'b0;
    run_op(K_DIV, 32'd100, 32'd7, 60, 1'b0, lat, ms, ds, nd, nb, dz, to, h0, l0);
    exp_hi = 32'd2; exp_lo = 32'd14;
    checks++; if (lat !== 12) begin failures++; $display("FAIL div_lat got=%0d exp=12", lat); end
    checks++; if (ds !== 1 || ms !== 0) begin failures++; $display("FAIL div_start got=%0d/%0d exp=1/0", ds, ms); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL div_done_count got=%0d exp=1", nd); end
    checks++; if (nb !== 12) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=12", nb); end
    checks++;
    if (HI !== exp_hi || LO !== exp_lo) begin
      failures++; $display("FAIL div_result got=%0d_%0d exp=%0d_%0d", HI, LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_div_zero();
    int lat, ms, ds, nd, nb, dz, to;
    logic [31:0] h0, l0;
    run_op(K_DIV, 32'd5, 32'd0, 20, 1'b0, lat, ms, ds, nd, nb, dz, to, h0, l0);
    checks++; if (lat !== 0) begin failures++; $display("FAIL dz_lat got=%0d exp=0", lat); end
    checks++; if (dz !== 1 || nd !== 1) begin failures++; $display("FAIL dz_flag got=%0d/%0d exp=1/1", dz, nd); end
    checks++; if (ds !== 0 || nb !== 0) begin failures++; $display("FAIL dz_no_start got=%0d/%0d exp=0/0", ds, nb); end
    checks++;
    if (HI !== exp_hi || LO !== exp_lo) begin
      failures++; $display("FAIL dz_hilo got=%h_%h exp=%h_%h", HI, LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_back_to_back();
    int lat, ms, ds, nd, nb, dz, to;
    logic [31:0] h0, l0, a, b;
    logic [63:0] p;
    a = $urandom; b = $urandom;
    run_op(K_MULT, a, b, 60, 1'b0, lat, ms, ds, nd, nb, dz, to, h0, l0);
    a = a ^ 32'h0F0F_1234; b = b + 32'd99;
    run_op(K_MULT, a, b, 60, 1'b0, lat, ms, ds, nd, nb, dz, to, h0, l0);
    p = mul64(a, b); exp_hi = p[63:32]; exp_lo = p[31:0];
    checks++; if (lat !== 34) begin failures++; $display("FAIL b2b_lat got=%0d exp=34", lat); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL b2b_done_count got=%0d exp=1", nd); end
    checks++;
    if (HI !== exp_hi || LO !== exp_lo) begin
      failures++; $display("FAIL b2b_result got=%h_%h exp=%h_%h", HI, LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_timeout();
    int lat, ms, ds, nd, nb, dz, to;
    logic [31:0] h0, l0;
    d_never = 1'b1;
    run_op(K_DIV, 32'd1000, 32'd3, 80, 1'b0, lat, ms, ds, nd, nb, dz, to, h0, l0);
    d_never = 1'b0;
    checks++; if (lat !== TO + 1) begin failures++; $display("FAIL to_lat got=%0d exp=%0d", lat, TO + 1); end
    checks++; if (to !== 1 || nd !== 1 || dz !== 0) begin failures++; $display("FAIL to_flags got=%0d/%0d/%0d exp=1/1/0", to, nd, dz); end
    checks++;
    if (HI !== exp_hi || LO !== exp_lo) begin
      failures++; $display("FAIL to_hilo got=%h_%h exp=%h_%h", HI, LO, exp_hi, exp_lo);
    end
    run_op(K_MTHI, 32'h0000_1234, 32'd0, 4, 1'b0, lat, ms, ds, nd, nb, dz, to, h0, l0);
    exp_hi = 32'h0000_1234;
    checks++; if (h0 !== exp_hi) begin failures++; $display("FAIL mthi_value got=%h exp=%h", h0, exp_hi); end
    checks++; if (nd !== 0 || nb !== 0) begin failures++; $display("FAIL mthi_quiet got=%0d/%0d exp=0/0", nd, nb); end
    checks++; if (LO !== exp_lo) begin failures++; $display("FAIL mthi_lo_kept got=%h exp=%h", LO, exp_lo); end
  endtask

  task automatic test_reset_mid();
    int lat, ms, ds, nd, nb, dz, to;
    logic [31:0] h0, l0, a, b;
    logic [63:0] p;
    run_op(K_MTLO, 32'hCAFE_0001, 32'd0, 4, 1'b0, lat, ms, ds, nd, nb, dz, to, h0, l0);
    exp_lo = 32'hCAFE_0001;
    @(negedge clock);
    op_valid = 1'b1; op = K_MULT; A = 32'd12345; B = 32'd678;
    @(posedge clock);
    @(negedge clock);
    op_valid = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0;
    checks++;
    if ({HI, LO, op_a, op_b} !== 128'd0) begin
      failures++; $display("FAIL rst_mid_regs got=%h/%h/%h/%h exp=0", HI, LO, op_a, op_b);
    end
    checks++;
    if ({busy, done, mult_start, div_start} !== 4'd0) begin
      failures++; $display("FAIL rst_mid_flags got=%b exp=0000", {busy, done, mult_start, div_start});
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    a = $urandom; b = $urandom;
    run_op(K_MULT, a, b, 60, 1'b1, lat, ms, ds, nd, nb, dz, to, h0, l0);
    p = mul64(a, b); exp_hi = p[63:32]; exp_lo = p[31:0];
    checks++; if (lat !== 34 || ms !== 1) begin failures++; $display("FAIL rst_after_mult got lat=%0d starts=%0d exp=34/1", lat, ms); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL rst_after_done got=%0d exp=1", nd); end
    checks++;
    if (HI !== exp_hi || LO !== exp_lo) begin
      failures++; $display("FAIL rst_after_result got=%h_%h exp=%h_%h", HI, LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_random();
    int lat, ms, ds, nd, nb, dz, to, e_lat, e_done, sel;
    logic [31:0] h0, l0, a, b;
    logic [63:0] p;
    for (int i = 0; i < 12; i++) begin
      sel = $urandom_range(0, 3); a = $urandom; b = $urandom;
      e_lat = -1; e_done = 0;
      case (sel)
        0: begin
          run_op(K_MULT, a, b, 60, 1'b0, lat, ms, ds, nd, nb, dz, to, h0, l0);
          p = mul64(a, b); exp_hi = p[63:32]; exp_lo = p[31:0]; e_lat = 34; e_done = 1;
        end
        1: begin
          if ($urandom_range(0, 3) == 0) b = '0;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
          d_lat = $urandom_range(1, 30);
          run_op(K_DIV, a, b, 60, 1'b0, lat, ms, ds, nd, nb, dz, to, h0, l0);
          e_done = 1;
          if (b == 0) e_lat = 0;
          else begin e_lat = d_lat + 2; exp_hi = rem(a, b); exp_lo = quo(a, b); end
        end
        2: begin
          run_op(K_MTHI, a, b, 4, 1'b0, lat, ms, ds, nd, nb, dz, to, h0, l0);
          exp_hi = a;
        end
        default: begin
          run_op(K_MTLO, a, b, 4, 1'b0, lat, ms, ds, nd, nb, dz, to, h0, l0);
          exp_lo = a;
        end
      endcase
      checks++;
      if (nd !== e_done || lat !== e_lat) begin
        failures++; $display("FAIL rand%0d_timing op=%0d got done=%0d lat=%0d exp done=%0d lat=%0d", i, sel, nd, lat, e_done, e_lat);
      end
      checks++;
      if (HI !== exp_hi || LO !== exp_lo) begin
        failures++; $display("FAIL rand%0d_hilo op=%0d got=%h_%h exp=%h_%h", i, sel, HI, LO, exp_hi, exp_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_div_basic();
    test_div_zero();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer between the multi-cycle control unit and the iterative multiplier/divider. It accepts one HI/LO-class operation at a time (MULT, DIV, MTHI, MTLO) and pulses the start of the selected arithmetic unit. It waits for that unit's end flag, filters stale end levels, and owns the architectural HI/LO registers read by MFHI/MFLO. It also raises busy, done, divide-by-zero and timeout indications back to the control unit.

## Interface
- `TIMEOUT`, default 40: maximum cycles spent waiting for an end flag before abort.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `op_valid`  in  1  operation request; sampled only in IDLE.
- `op`  in  2  operation code: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- `A`, `B`  in  32 each  rs / rt operands, signed two's complement.
- `mult_start`  out  1  one-cycle start pulse to the multiplier.
- `mult_hi`, `mult_lo`  in  32 each  multiplier result.
- `mult_end`  in  1  multiplier end flag; level that stays high after completion.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_hi`, `div_lo`  in  32 each  divider remainder / quotient.
- `div_end`  in  1  divider end flag; same level semantics as `mult_end`.
- `op_a`, `op_b`  out  32 each  latched operands driven to both units.
- `HI`, `LO`  out  32 each  architectural registers.
- `busy`  out  1  high from the cycle after MULT/DIV acceptance until done.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  one-cycle pulse, coincident with `done`, for DIV with B == 0.
- `timeout`  out  1  one-cycle pulse, coincident with `done`, on watchdog abort.

## Operation
- States: IDLE, M_START, M_WAIT, D_START, D_WAIT, DONE.
- Reset values: every output 0, `HI`/`LO` 0, state IDLE, watchdog 0.
- IDLE with op_valid:
  - MULT: latch A/B into `op_a`/`op_b`; go to M_START.
  - DIV with B != 0: latch A/B; go to D_START.
  - DIV with B == 0: go to DONE with `div_zero` set; no `div_start`; HI/LO unchanged.
  - MTHI / MTLO: HI <= A / LO <= A on the same edge; stay IDLE; no busy and no done.
- M_START / D_START: the matching start output is high for exactly this state; the end input is ignored here. Next state is M_WAIT / D_WAIT, and the watchdog clears.
- M_WAIT / D_WAIT: the watchdog increments each cycle.
  - End input high: HI <= *_hi, LO <= *_lo; go to DONE.
  - Watchdog reaches TIMEOUT with no end: go to DONE with `timeout` set; HI/LO unchanged.
- DONE: `done` high for one cycle, plus any flag; then IDLE.
- `op_valid` outside IDLE is ignored; the control unit must hold the request until `busy` is low.
- End flags are sampled only in *_WAIT states. A stale high level left from the previous operation is never captured, because the unit clears it on the edge that samples start.
- End inputs of the unit not currently selected are ignored.

## Timing
- Acceptance edge E0.
- MULT with nominal 32-iteration multiplier:
  - `mult_start` high in cycle E0–E1.
  - `mult_end` rises after E33.
  - HI/LO update at E34.
  - `done` high E34–E35.
  - `busy` high E0–E34.
- DIV: latency is `div_end` arrival plus 1 capture cycle plus 1 DONE cycle.
- DIV by zero: `done` and `div_zero` high for cycle E0–E1.
- Timeout: `done` and `timeout` high TIMEOUT+1 cycles after the start pulse.
- Reset asserted mid-operation: outputs drop asynchronously, including start pulses. The arithmetic units are reset by the same net, so no partial result is ever captured.
- MTHI/MTLO: the written value is visible on HI/LO the cycle after E0.

## Structure
- Shared package `muldiv_pkg`:
  - op encoding constants (OP_MULT, OP_DIV, OP_MTHI, OP_MTLO);
  - state encoding;
  - default TIMEOUT.
- One natural sub-module, `muldiv_watchdog`: clearable up-counter with a terminal-count compare against TIMEOUT. Everything else lives in the single FSM module.

## Test plan
- MULT A=7, B=-3 with a real multiplier → HI=0xFFFFFFFF, LO=0xFFFFFFEB; `done` 34 cycles after acceptance; `mult_start` exactly one cycle wide.
- DIV A=100, B=7 with a divider stub ending after 10 cycles → LO=14, HI=2; `div_start` one cycle; `done` once.
- DIV A=5, B=0 → `div_zero`+`done` the cycle after acceptance; `div_start` never asserted; HI/LO keep their prior values.
- Back-to-back MULTs with `mult_end` still high from the first → second result equals the second product, not the first; no early `done`.
- Stub never asserts `div_end`, TIMEOUT=40 → `timeout`+`done` pulse; HI/LO unchanged; next MTHI A=0x1234 → HI=0x1234.
- `reset` low 10 cycles into a MULT → outputs and HI/LO zero immediately; after release, `op_valid` pulses while busy are ignored and a new MULT completes normally.
